// File: rtl/cdc_word_serializer.sv
// cdc_word_serializer
//   Splits a wide upstream word into BEATS narrow beats and writes them into
//   the write port of an async FIFO. Beat 0 is cA_data_i[DATA_WIDTH-1:0] and
//   is written first. One word is in flight at a time: the block accepts a
//   new word only in IDLE.
//
//   Optional feature: define CDC_SER_CHECKSUM_EN to append one extra beat
//   after the last data beat. That beat is the XOR of all data beats. With
//   the macro undefined there is no CHK state and no checksum logic.
//
// Ports
//   clkA_i      write-domain clock (rising edge)
//   cA_rst_ni   async active-low reset
//   cA_valid_i  upstream word valid
//   cA_data_i   upstream word, DATA_WIDTH*BEATS bits
//   cA_ready_o  high only in IDLE
//   cA_we_o     FIFO write enable (combinational from state)
//   cA_dout_o   beat presented to the FIFO
//   cA_wrdy_i   FIFO not full; a beat completes on cA_we_o & cA_wrdy_i
//   cA_busy_o   high while a word is being serialized
//   cA_words_o  completed-word counter, wraps at 16 bits
module cdc_word_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int BEATS      = 4
) (
  input  logic                        clkA_i,
  input  logic                        cA_rst_ni,
  input  logic                        cA_valid_i,
  input  logic [DATA_WIDTH*BEATS-1:0] cA_data_i,
  output logic                        cA_ready_o,
  output logic                        cA_we_o,
  output logic [DATA_WIDTH-1:0]       cA_dout_o,
  input  logic                        cA_wrdy_i,
  output logic                        cA_busy_o,
  output logic [15:0]                 cA_words_o
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

`ifdef CDC_SER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CHK} state_e;
`else
  typedef enum logic [0:0] {IDLE, SEND} state_e;
`endif

  typedef logic [BEATS-1:0][DATA_WIDTH-1:0] word_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_q,  beat_d;
  word_t            hold_q,  hold_d;
  logic [15:0]      words_q, words_d;
  word_t            in_beats;

  assign in_beats   = word_t'(cA_data_i);
  assign cA_words_o = words_q;

`ifdef CDC_SER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_q, chk_d;
  logic [DATA_WIDTH-1:0] in_xor;

  // Checksum is taken from the incoming word at capture so the CHK beat is
  // ready the moment the last data beat completes.
  always_comb begin
    in_xor = '0;
    for (int i = 0; i < BEATS; i++) in_xor = in_xor ^ in_beats[i];
  end
`endif

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    hold_d     = hold_q;
    words_d    = words_q;
`ifdef CDC_SER_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    cA_ready_o = 1'b0;
    cA_we_o    = 1'b0;
    cA_busy_o  = 1'b1;
    cA_dout_o  = '0;

    case (state_q)
      IDLE: begin
        cA_ready_o = 1'b1;
        cA_busy_o  = 1'b0;
        if (cA_valid_i) begin
          hold_d  = in_beats;
          beat_d  = '0;
`ifdef CDC_SER_CHECKSUM_EN
          chk_d   = in_xor;
`endif
          state_d = SEND;
        end
      end

      SEND: begin
        cA_we_o   = 1'b1;
        cA_dout_o = hold_q[beat_q];
        // Everything holds while the FIFO is full.
        if (cA_wrdy_i) begin
          if (beat_q == LAST_BEAT) begin
`ifdef CDC_SER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = IDLE;
            words_d = words_q + 16'd1;
`endif
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

`ifdef CDC_SER_CHECKSUM_EN
      CHK: begin
        cA_we_o   = 1'b1;
        cA_dout_o = chk_q;
        if (cA_wrdy_i) begin
          state_d = IDLE;
          words_d = words_q + 16'd1;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkA_i or negedge cA_rst_ni) begin
    if (!cA_rst_ni) begin
      state_q <= IDLE;
      beat_q  <= '0;
      hold_q  <= '0;
      words_q <= '0;
`ifdef CDC_SER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      hold_q  <= hold_d;
      words_q <= words_d;
`ifdef CDC_SER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_cdc_word_serializer.sv
module tb_cdc_word_serializer;

  localparam int DW = 8;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [31:0]   data = '0;
  logic          ready;
  logic          we;
  logic [DW-1:0] dout;
  logic          wrdy = 1'b1;
  logic          busy;
  logic [15:0]   words;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] words_exp = '0;

  always #5 clk = ~clk;

  cdc_word_serializer #(.DATA_WIDTH(DW), .BEATS(NB)) dut (
    .clkA_i     (clk),
    .cA_rst_ni  (rst_n),
    .cA_valid_i (valid),
    .cA_data_i  (data),
    .cA_ready_o (ready),
    .cA_we_o    (we),
    .cA_dout_o  (dout),
    .cA_wrdy_i  (wrdy),
    .cA_busy_o  (busy),
    .cA_words_o (words)
  );

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_word(input logic [31:0] d, input int mode, input bit hold);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] x;
    int idx, stall, cyc;
    x = '0;
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back(d[i*DW +: DW]);
      x = x ^ d[i*DW +: DW];
    end
`ifdef CDC_SER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    @(negedge clk);
    valid = 1'b1;
    data  = d;
    wrdy  = 1'b1;
    #1;
    chk("ready_before_accept", ready === 1'b1, ready, 1'b1);
    @(posedge clk);
    idx = 0; stall = 0; cyc = 0;
    while (idx < exp_q.size() && cyc < 100) begin
      @(negedge clk);
      cyc++;
      valid = hold;
      data  = $urandom;
      case (mode)
        1:       if (idx == 1 && stall < 3) begin wrdy = 1'b0; stall++; end
                 else wrdy = 1'b1;
        2:       wrdy = 1'($urandom_range(0, 1));
        default: wrdy = 1'b1;
      endcase
      #1;
      if (cyc == 1) begin
        chk("first_beat_latency_we", we === 1'b1, we, 1'b1);
        chk("busy_in_word", busy === 1'b1, busy, 1'b1);
        chk("ready_in_word", ready === 1'b0, ready, 1'b0);
      end
      chk("we_in_word", we === 1'b1, we, 1'b1);
      chk("dout_beat", dout === exp_q[idx], dout, exp_q[idx]);
      if (wrdy) idx++;
    end
    chk("writes_total", idx == exp_q.size(), idx, exp_q.size());
    @(negedge clk);
    valid = 1'b0;
    wrdy  = 1'b1;
    #1;
    words_exp = words_exp + 16'd1;
    chk("idle_ready", ready === 1'b1, ready, 1'b1);
    chk("idle_we", we === 1'b0, we, 1'b0);
    chk("idle_busy", busy === 1'b0, busy, 1'b0);
    chk("idle_dout", dout === 8'h00, dout, 8'h00);
    chk("words_count", words === words_exp, words, words_exp);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", ready === 1'b1, ready, 1'b1);
    chk("rst_we", we === 1'b0, we, 1'b0);
    chk("rst_dout", dout === 8'h00, dout, 8'h00);
    chk("rst_busy", busy === 1'b0, busy, 1'b0);
    chk("rst_words", words === 16'h0000, words, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    run_word(32'h44332211, 0, 1'b0);
    run_word(32'h44332211, 1, 1'b0);

    for (int w = 0; w < 6; w++) run_word($urandom, 2, 1'b0);

    @(negedge clk);
    valid = 1'b1;
    data  = 32'h44332211;
    wrdy  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    #1;
    chk("midrst_first_beat", dout === 8'h11, dout, 8'h11);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    words_exp = '0;
    chk("midrst_we", we === 1'b0, we, 1'b0);
    chk("midrst_ready", ready === 1'b1, ready, 1'b1);
    chk("midrst_dout", dout === 8'h00, dout, 8'h00);
    chk("midrst_words", words === words_exp, words, words_exp);
    @(negedge clk);
    rst_n = 1'b1;
    run_word(32'hDDCCBBAA, 0, 1'b0);

    @(negedge clk);
    force dut.words_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.words_q;
    #1;
    words_exp = 16'hFFFF;
    chk("preload_words", words === 16'hFFFF, words, 16'hFFFF);
    run_word($urandom, 0, 1'b1);
    chk("words_wrapped", words === 16'h0000, words, 16'h0000);
    repeat (2) @(negedge clk);
    #1;
    chk("no_second_capture_we", we === 1'b0, we, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cdc_word_serializer.md
CDC_WORD_SERIALIZER -- requirements
Module: cdc_word_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the beat width, which matches the async FIFO write-port width.
REQ-002 SHALL have parameter BEATS, default 4, the number of DATA_WIDTH beats per input word; legal range is 2..16.
REQ-003 SHALL have port clkA_i, input, 1 bit: write-domain clock; all logic is on its rising edge.
REQ-004 SHALL have port cA_rst_ni, input, 1 bit: reset, asynchronous, active-low; clock clkA_i.
REQ-005 SHALL have port cA_valid_i, input, 1 bit: upstream word valid.
REQ-006 SHALL have port cA_data_i, input, DATA_WIDTH*BEATS bits: upstream word; beat 0 is bits [DATA_WIDTH-1:0].
REQ-007 SHALL have port cA_ready_o, output, 1 bit: block can accept a word.
REQ-008 SHALL have port cA_we_o, output, 1 bit: write enable to the async FIFO.
REQ-009 SHALL have port cA_dout_o, output, DATA_WIDTH bits: beat presented to the FIFO.
REQ-010 SHALL have port cA_wrdy_i, input, 1 bit: FIFO not full.
REQ-011 SHALL have port cA_busy_o, output, 1 bit: serialization in progress.
REQ-012 SHALL have port cA_words_o, output, 16 bits: count of completed words.

Function
REQ-013 SHALL implement FSM states IDLE, SEND and CHK, where CHK exists only when the macro in REQ-029 is defined.
REQ-014 SHALL drive cA_ready_o=1 only in IDLE and cA_busy_o=1 only in states other than IDLE.
REQ-015 SHALL, on an upstream transfer (cA_valid_i & cA_ready_o at a rising edge), capture cA_data_i into a holding register, clear the beat counter to 0 and enter SEND.
REQ-016 SHALL ignore cA_valid_i and cA_data_i whenever cA_ready_o=0; a held-off word is not captured.
REQ-017 SHALL drive cA_we_o combinationally, equal to 1 in SEND or CHK and 0 in IDLE.
REQ-018 SHALL drive cA_dout_o combinationally as holding-register beat[beat counter] in SEND, as the checksum in CHK, and as all-zeros in IDLE.
REQ-019 SHALL complete a beat write only on the cycle where cA_we_o & cA_wrdy_i=1.
REQ-020 SHALL, while cA_wrdy_i=0, hold cA_we_o, cA_dout_o and the beat counter stable; beats are never skipped or duplicated.
REQ-021 SHALL, on each completed beat in SEND, increment the beat counter by 1 (width $clog2(BEATS)).
REQ-022 SHALL, on the completed beat BEATS-1, go to IDLE (or to CHK when the checksum is enabled) instead of incrementing the counter.
REQ-023 SHALL increment cA_words_o by 1 when the final beat of a word completes, wrapping from 0xFFFF to 0x0000.
REQ-024 SHALL present the first beat on cA_we_o in the cycle following the accepting edge, giving a latency of 1 cycle.
REQ-025 SHALL take at least BEATS+1 cycles per word without the checksum and BEATS+2 with it; there is no back-to-back acceptance.

Reset
REQ-026 SHALL, while cA_rst_ni=0 and independent of clkA_i, force state IDLE, beat counter 0, holding register 0, checksum 0 and cA_words_o=0x0000.
REQ-027 SHALL drive outputs during reset as cA_ready_o=1, cA_we_o=0, cA_dout_o=0 and cA_busy_o=0.
REQ-028 SHALL, on reset asserted mid-word, discard the remaining beats; after reset release the next word starts at beat 0.

Configuration
REQ-029 SHALL, when macro CDC_SER_CHECKSUM_EN is defined, append one CHK beat after beat BEATS-1 equal to the XOR of all BEATS data beats; the CHK beat obeys REQ-019/REQ-020 and cA_words_o increments when it completes.
REQ-030 SHALL, when CDC_SER_CHECKSUM_EN is undefined, contain no CHK state and no checksum logic; a word is exactly BEATS beats.

Verification
REQ-031 SHALL cover reset: assert cA_rst_ni=0 -> cA_ready_o=1, cA_we_o=0, cA_dout_o=0x00, cA_busy_o=0, cA_words_o=0.
REQ-032 SHALL cover a streaming word: DATA_WIDTH=8, BEATS=4, cA_data_i=0x44332211, cA_wrdy_i=1 -> cA_dout_o=0x11,0x22,0x33,0x44 on 4 consecutive cycles, then cA_ready_o=1 and cA_words_o=1.
REQ-033 SHALL cover backpressure: cA_wrdy_i=0 for 3 cycles while cA_dout_o=0x22 -> 0x22 and cA_we_o=1 held for 3 cycles, then 0x33 follows, with 4 writes total.
REQ-034 SHALL cover the checksum: with CDC_SER_CHECKSUM_EN defined, word 0x44332211 -> 5 writes 0x11,0x22,0x33,0x44,0x44.
REQ-035 SHALL cover reset mid-word: pulse cA_rst_ni low after beat 0x11 completes -> cA_we_o=0 next; a new word 0xDDCCBBAA then emits 0xAA first.
REQ-036 SHALL cover the counter wrap and held-off valid: preload 0xFFFF completed words, hold cA_valid_i=1 during SEND -> only one capture, then cA_words_o wraps to 0x0000.
